// File: rtl/npu_pkg.sv
// Shared NPU types and constants used by the result drain path.
package npu_pkg;

  localparam int ARRAY_N  = 7;
  localparam int ACC_W    = 32;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef logic [ARRAY_N-1:0][ACC_W-1:0] acc_row_t;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_e;

endpackage

// File: rtl/result_drain_if.sv
// Result-matrix capture and row-stream signals for result_drain.
// i_shift is present only when RESULT_REQUANT_EN is defined.
interface result_drain_if
  import npu_pkg::*;
#(
  parameter int N = ARRAY_N
) ();

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][N-1:0][ACC_W-1:0] i_c;
  logic                           i_validResult;
  logic                           o_ready;
  logic [N-1:0][ACC_W-1:0]        o_rowData;
  logic                           o_rowValid;
  logic                           i_rowReady;
  logic [IDX_W-1:0]               o_rowIdx;
  logic                           o_last;
  logic                           o_overrun;
`ifdef RESULT_REQUANT_EN
  logic [4:0]                     i_shift;
`endif

  modport slave (
    input  i_c,
    input  i_validResult,
    input  i_rowReady,
`ifdef RESULT_REQUANT_EN
    input  i_shift,
`endif
    output o_ready,
    output o_rowData,
    output o_rowValid,
    output o_rowIdx,
    output o_last,
    output o_overrun
  );

  modport master (
    output i_c,
    output i_validResult,
    output i_rowReady,
`ifdef RESULT_REQUANT_EN
    output i_shift,
`endif
    input  o_ready,
    input  o_rowData,
    input  o_rowValid,
    input  o_rowIdx,
    input  o_last,
    input  o_overrun
  );

endinterface

// File: rtl/result_drain_sat_shift.sv
// Per-element arithmetic right shift with saturation to the int8 range,
// sign-extended back to the accumulator width.
module sat_shift_int8
  import npu_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] val_i,
  input  logic [4:0]   shift_i,
  output logic [W-1:0] val_o
);

  localparam logic signed [W-1:0] MAXV = W'(INT8_MAX);
  localparam logic signed [W-1:0] MINV = W'(INT8_MIN);

  logic signed [W-1:0] shifted;

  always_comb begin
    shifted = $signed(val_i) >>> shift_i;
    if (shifted > MAXV) begin
      val_o = MAXV;
    end else if (shifted < MINV) begin
      val_o = MINV;
    end else begin
      val_o = shifted;
    end
  end

endmodule

// File: rtl/result_drain.sv
// Captures the N x N result matrix and streams it out one row per beat.
// Build option: RESULT_REQUANT_EN adds int8 shift/saturate on the output rows.
module result_drain
  import npu_pkg::*;
#(
  parameter int N = ARRAY_N
) (
  input  logic           i_clk,
  input  logic           i_arst,
  result_drain_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  drain_state_e                   state_q;
  logic                           valid_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           overrun_q;
  logic [N-1:0][N-1:0][ACC_W-1:0] buf_q;
`ifdef RESULT_REQUANT_EN
  logic [4:0]                     shift_q;
`endif

  logic                    hs;
  logic                    last;
  logic                    ready;
  logic                    capture;
  logic [N-1:0][ACC_W-1:0] raw_row;

  assign hs      = valid_q && bus.i_rowReady;
  assign last    = valid_q && (idx_q == LAST_IDX);
  assign ready   = (state_q == IDLE) || (hs && last);
  assign capture = bus.i_validResult && ready;

  // Capture takes priority over the final-row handshake so a result
  // arriving on the last beat restarts the stream with no bubble.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      buf_q     <= '0;
`ifdef RESULT_REQUANT_EN
      shift_q   <= '0;
`endif
    end else begin
      if (capture) begin
        buf_q   <= bus.i_c;
        idx_q   <= '0;
        state_q <= STREAM;
        valid_q <= 1'b1;
`ifdef RESULT_REQUANT_EN
        shift_q <= bus.i_shift;
`endif
      end else if (hs) begin
        if (idx_q == LAST_IDX) begin
          idx_q   <= '0;
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
      if (bus.i_validResult && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign raw_row = buf_q[idx_q];

`ifdef RESULT_REQUANT_EN
  for (genvar g = 0; g < N; g++) begin : g_sat
    sat_shift_int8 #(.W(ACC_W)) u_sat (
      .val_i   (raw_row[g]),
      .shift_i (shift_q),
      .val_o   (bus.o_rowData[g])
    );
  end
`else
  assign bus.o_rowData = raw_row;
`endif

  assign bus.o_ready    = ready;
  assign bus.o_rowValid = valid_q;
  assign bus.o_rowIdx   = idx_q;
  assign bus.o_last     = last;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: drain, backpressure, back-to-back,
// overrun, async reset mid-stream, and optional requant rows.
module tb_result_drain;
  import npu_pkg::*;

  localparam int N = 7;
  typedef logic [N-1:0][31:0] row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_shift = 0;

  result_drain_if #(.N(N)) bus ();

  result_drain #(.N(N)) dut (
    .i_clk  (clk),
    .i_arst (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int elem(input int add, input int r, input int c);
    int v;
    v = (r + 1) * (c + 1) * 140 + add;
`ifdef RESULT_REQUANT_EN
    v = v >>> tb_shift;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return v;
  endfunction

  function automatic row_t exp_row(input int add, input int r);
    row_t x;
    for (int c = 0; c < N; c++) x[c] = 32'(elem(add, r, c));
    return x;
  endfunction

  task automatic load(input int add);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bus.i_c[r][c] = 32'((r + 1) * (c + 1) * 140 + add);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input string tag, input int add, input int r);
    check({tag, "_valid"}, 256'(bus.o_rowValid), 256'(1));
    check({tag, "_idx"},   256'(bus.o_rowIdx),   256'(r));
    check({tag, "_data"},  256'(bus.o_rowData),  256'(exp_row(add, r)));
    check({tag, "_last"},  256'(bus.o_last),     256'(r == N - 1));
  endtask

  task automatic capture(input int add);
    load(add);
    bus.i_validResult = 1'b1;
    check("cap_ready", 256'(bus.o_ready), 256'(1));
    tick();
    bus.i_validResult = 1'b0;
  endtask

  initial begin
    int   exp_idx;
    int   k;
    row_t rq;

    bus.i_c           = '0;
    bus.i_validResult = 1'b0;
    bus.i_rowReady    = 1'b0;
`ifdef RESULT_REQUANT_EN
    bus.i_shift       = '0;
`endif

    // Reset state
    #12;
    check("rst_valid",   256'(bus.o_rowValid), 256'(0));
    check("rst_idx",     256'(bus.o_rowIdx),   256'(0));
    check("rst_last",    256'(bus.o_last),     256'(0));
    check("rst_overrun", 256'(bus.o_overrun),  256'(0));
    check("rst_data",    256'(bus.o_rowData),  256'(0));
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 256'(bus.o_ready), 256'(1));

    // Basic drain, rowReady held high
    bus.i_rowReady = 1'b1;
    capture(0);
    for (int r = 0; r < N; r++) begin
      expect_row("basic", 0, r);
      check("basic_ready", 256'(bus.o_ready), 256'(r == N - 1));
      tick();
    end
    check("basic_idle_valid", 256'(bus.o_rowValid), 256'(0));
    check("basic_idle_ready", 256'(bus.o_ready),    256'(1));

    // Backpressure: rowReady 1,0,0,1,0,0,...
    capture(2);
    exp_idx = 0;
    k = 0;
    while (exp_idx < N && k < 40) begin
      bus.i_rowReady = (k % 3 == 0);
      expect_row("bp", 2, exp_idx);
      tick();
      if (bus.i_rowReady) exp_idx++;
      k++;
    end
    check("bp_all_rows", 256'(exp_idx), 256'(N));
    check("bp_idle", 256'(bus.o_rowValid), 256'(0));

    // Back-to-back capture on the final handshake
    bus.i_rowReady = 1'b1;
    capture(0);
    for (int r = 0; r < N - 1; r++) begin
      expect_row("b2b_a", 0, r);
      tick();
    end
    expect_row("b2b_a", 0, N - 1);
    load(1);
    bus.i_validResult = 1'b1;
    check("b2b_ready", 256'(bus.o_ready), 256'(1));
    tick();
    bus.i_validResult = 1'b0;
    for (int r = 0; r < N; r++) begin
      expect_row("b2b_b", 1, r);
      tick();
    end
    check("b2b_overrun", 256'(bus.o_overrun), 256'(0));

    // Overrun during row 3
    capture(0);
    for (int r = 0; r < 3; r++) tick();
    expect_row("ovr", 0, 3);
    load(3);
    bus.i_validResult = 1'b1;
    check("ovr_ready", 256'(bus.o_ready), 256'(0));
    tick();
    bus.i_validResult = 1'b0;
    check("ovr_flag", 256'(bus.o_overrun), 256'(1));
    for (int r = 4; r < N; r++) begin
      expect_row("ovr_keep", 0, r);
      tick();
    end
    check("ovr_sticky", 256'(bus.o_overrun),  256'(1));
    check("ovr_idle",   256'(bus.o_rowValid), 256'(0));

    // Async reset during row 2
    capture(2);
    tick();
    tick();
    expect_row("rstm", 2, 2);
    bus.i_rowReady = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstm_valid",   256'(bus.o_rowValid), 256'(0));
    check("rstm_overrun", 256'(bus.o_overrun),  256'(0));
    check("rstm_idx",     256'(bus.o_rowIdx),   256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_rowReady = 1'b1;
    check("rstm_ready", 256'(bus.o_ready), 256'(1));
    capture(4);
    for (int r = 0; r < N; r++) begin
      expect_row("rstm_new", 4, r);
      tick();
    end

`ifdef RESULT_REQUANT_EN
    // Requant: shift 2 on row 0, then a negative saturating element
    tb_shift = 2;
    bus.i_shift = 5'd2;
    capture(0);
    rq[0] = 32'd35;  rq[1] = 32'd70;  rq[2] = 32'd105; rq[3] = 32'd127;
    rq[4] = 32'd127; rq[5] = 32'd127; rq[6] = 32'd127;
    check("rq_row0", 256'(bus.o_rowData), 256'(rq));
    for (int r = 0; r < N; r++) begin
      expect_row("rq", 0, r);
      tick();
    end
    load(0);
    bus.i_c[0][0] = -32'sd1000;
    bus.i_validResult = 1'b1;
    tick();
    bus.i_validResult = 1'b0;
    check("rq_neg_sat", 256'(bus.o_rowData[0]), 256'(32'hFFFF_FF80));
    for (int r = 0; r < N; r++) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Consumer end of the systolic-array result interface.
- Captures the full N×N 32-bit result matrix on the array's result-valid pulse into a local buffer.
- Streams the buffer out one row per beat on a valid/ready interface toward the writeback/requant path.
- Reports readiness so the controller can time the next i_validInput, and flags results that arrive while it is busy.

Parameters:
- N, 7, matrix dimension (rows/cols); must match topSystolicArray N.
- ACC_W, 32, accumulator element width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  asynchronous reset, active-low.
- i_c  in  [N-1:0][N-1:0][ACC_W-1:0]  result matrix from array; i_c[row][col].
- i_validResult  in  1  single-cycle pulse; i_c valid this cycle.
- o_ready  out  1  a capture in this cycle would be accepted.
- o_rowData  out  [N-1:0][ACC_W-1:0]  current row.
- o_rowValid  out  1  o_rowData valid.
- i_rowReady  in  1  downstream accepts the row.
- o_rowIdx  out  $clog2(N)  index of the current row.
- o_last  out  1  current row is row N-1.
- o_overrun  out  1  sticky: a result was dropped.
- i_shift  in  5  requant shift amount; present only with RESULT_REQUANT_EN.

Behaviour:
- Reset (i_arst low, async): state IDLE, o_rowValid=0, o_rowIdx=0, o_last=0, o_overrun=0, o_rowData=0, buffer=0. o_ready=1 once reset deasserts.
- FSM states:
  - IDLE: o_rowValid=0.
  - STREAM: o_rowValid=1.
- IDLE + i_validResult → register i_c into buffer, rowIdx=0, go to STREAM. Row 0 is valid on the next cycle (latency 1).
- STREAM beat: a handshake occurs when o_rowValid && i_rowReady.
  - On a handshake with rowIdx<N-1: rowIdx increments.
  - On a handshake with rowIdx==N-1: return to IDLE.
- While o_rowValid && !i_rowReady: o_rowData, o_rowIdx and o_last are held stable.
- o_rowData = buffer[o_rowIdx]. o_last = (o_rowIdx==N-1) && o_rowValid.
- o_ready is combinational: (state==IDLE) || (o_rowValid && i_rowReady && o_last).
- Simultaneous events:
  - i_validResult coincides with the final-row handshake → capture is accepted. The buffer is overwritten at that edge (old row N-1 already consumed). Stay in STREAM with rowIdx=0, new row 0 valid next cycle. There is no bubble.
  - i_validResult while o_ready=0 → input ignored, buffer untouched, o_overrun set to 1. o_overrun clears only on reset.
- Reset mid-stream aborts immediately. No further beats; the partial matrix is discarded.
- i_rowReady high in IDLE is ignored.
- Minimum drain time is N cycles per matrix with i_rowReady held high.

Optional Feature:
- Macro: RESULT_REQUANT_EN.
- Defined:
  - i_shift port exists and is sampled at capture time, stored with the buffer.
  - Each output element = arithmetic right shift of the buffered signed value by the stored shift, saturated to [-128,127], sign-extended to ACC_W.
  - The transform is combinational on the output path, so latency is unchanged.
- Undefined: i_shift is absent and elements pass through unmodified.

Decomposition:
- Shared package npu_pkg holds:
  - ACC_W localparam;
  - typedef acc_row_t = [N-1:0][ACC_W-1:0];
  - drain_state_e enum {IDLE, STREAM};
  - INT8_MAX=127 and INT8_MIN=-128 constants.
- One sub-module is natural: sat_shift_int8, the per-element shift+saturate unit. It is instantiated N times under RESULT_REQUANT_EN.

Test Plan:
- Basic drain:
  - Stimulus: N=7, i_c[i][j]=(i+1)*(j+1)*140, i_validResult pulse, i_rowReady=1.
  - Response: rows 0..6 appear on 7 consecutive cycles starting 1 cycle after the pulse; row0 = 140,280,…,980; o_last only on row 6; o_ready back to 1 in the cycle of the last beat.
- Backpressure:
  - Stimulus: i_rowReady toggles 1,0,0,1,…
  - Response: each row held stable while stalled; all 7 rows delivered in order with no duplicates.
- Back-to-back:
  - Stimulus: second i_validResult in the same cycle as the row-6 handshake, with matrix values +1.
  - Response: new row0 (141,281,…) appears next cycle; o_overrun stays 0.
- Overrun:
  - Stimulus: i_validResult during row 3 of a stream.
  - Response: o_overrun=1 and stays 1; rows 4..6 still carry the original matrix data.
- Reset mid-stream:
  - Stimulus: i_arst driven low during row 2.
  - Response: o_rowValid=0 and o_overrun=0 immediately (asynchronously); after release, o_ready=1 and a new capture streams from row 0.
- RESULT_REQUANT_EN:
  - Stimulus: i_shift=2, row0 = 140,…,980.
  - Response: row0 = 35,70,105,127,127,127,127.
  - Stimulus: element -1000 with shift 2.
  - Response: -128.
